// File: rtl/num_sep_drain_ctrl_pkg.sv
// Shared types for the number-separator drain controller: FSM states and
// error codes reported to the command FSM.
package num_sep_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CLEAR,
    WAIT,
    CHECK,
    READ,
    LATCH,
    OUT,
    DONE,
    ERR
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_INVALID = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_COUNT   = 2'd3;

  // Wide enough for any practical clear length or wait timeout.
  localparam int CNT_WIDTH = 32;

endpackage

// File: rtl/num_sep_drain_ctrl_timeout_cnt.sv
// Loadable down-counter with enable; tc is high while the count sits at zero.
// Shared between the buffer-clear length and the separator wait timeout.
module num_sep_timeout_cnt #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Load wins over decrement; the count parks at zero instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/num_sep_drain_ctrl.sv
// Session controller: clears the separator, waits for its verdict, then drains
// the parsed values from the result RAM as a valid/ready stream.
module num_sep_drain_ctrl
  import num_sep_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 11,
  parameter int MAX_COUNT      = 2048,
  parameter int CLEAR_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  sep_buf_clear,
  input  logic                  sep_done,
  input  logic                  sep_invalid,
  input  logic [ADDR_WIDTH:0]   sep_num_count,
  output logic [ADDR_WIDTH-1:0] sep_rd_addr,
  input  logic [DATA_WIDTH-1:0] sep_rd_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  ok_pulse,
  output logic                  err_pulse,
  output logic [1:0]            err_code
);

  localparam int CW = CNT_WIDTH;
  localparam logic [CW-1:0] CLEAR_LOAD   = CW'(CLEAR_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LOAD =
    (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH:0] MAX_CNT = (ADDR_WIDTH + 1)'(MAX_COUNT);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH:0]     count_q, count_d;
  logic [ADDR_WIDTH:0]     idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [ADDR_WIDTH-1:0]   out_index_q, out_index_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic [1:0]              err_code_q, err_code_d;

  logic                    tmr_load, tmr_en, tmr_tc;
  logic [CW-1:0]           tmr_val;

  num_sep_timeout_cnt #(
    .WIDTH(CW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(tmr_val),
    .en      (tmr_en),
    .tc      (tmr_tc)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    idx_d       = idx_q;
    rd_addr_d   = rd_addr_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    err_code_d  = err_code_q;
    tmr_load    = 1'b0;
    tmr_val     = CLEAR_LOAD;
    tmr_en      = 1'b0;

    unique case (state_q)
      IDLE: begin
        tmr_load = 1'b1;
        if (start && !abort) begin
          err_code_d = ERR_NONE;
          state_d    = CLEAR;
        end
      end
      CLEAR: begin
        tmr_en = 1'b1;
        if (tmr_tc) begin
          tmr_load = 1'b1;
          tmr_val  = TIMEOUT_LOAD;
          state_d  = WAIT;
        end
      end
      // Invalid outranks done so a malformed packet never gets drained.
      WAIT: begin
        tmr_en = (TIMEOUT_CYCLES != 0);
        if (sep_invalid) begin
          err_code_d = ERR_INVALID;
          state_d    = ERR;
        end else if (sep_done) begin
          count_d = sep_num_count;
          state_d = CHECK;
        end else if ((TIMEOUT_CYCLES != 0) && tmr_tc) begin
          err_code_d = ERR_TIMEOUT;
          state_d    = ERR;
        end
      end
      CHECK: begin
        if ((count_q == '0) || (count_q > MAX_CNT)) begin
          err_code_d = ERR_COUNT;
          state_d    = ERR;
        end else begin
          idx_d     = '0;
          rd_addr_d = '0;
          state_d   = READ;
        end
      end
      READ: begin
        state_d = LATCH;
      end
      // RAM data for the address presented in READ is valid this cycle.
      LATCH: begin
        out_data_d  = sep_rd_data;
        out_index_d = idx_q[ADDR_WIDTH-1:0];
        out_last_d  = (idx_q == (count_q - 1'b1));
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            state_d = DONE;
          end else begin
            idx_d     = idx_q + 1'b1;
            rd_addr_d = idx_d[ADDR_WIDTH-1:0];
            state_d   = READ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      ERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort silently drops the session, including any pending verdict.
    if (abort) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      err_code_d  = err_code_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      idx_q       <= '0;
      rd_addr_q   <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      rd_addr_q   <= rd_addr_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      err_code_q  <= err_code_d;
    end
  end

  assign sep_buf_clear = (state_q == CLEAR);
  assign busy          = (state_q != IDLE);
  assign ok_pulse      = (state_q == DONE);
  assign err_pulse     = (state_q == ERR);
  assign sep_rd_addr   = rd_addr_q;
  assign out_data      = out_data_q;
  assign out_index     = out_index_q;
  assign out_valid     = out_valid_q;
  assign out_last      = out_last_q;
  assign err_code      = err_code_q;

endmodule

// File: tb/tb_num_sep_drain_ctrl.sv
// Bench for num_sep_drain_ctrl: behavioural separator RAM plus a scoreboard
// of expected stream elements checked at every handshake.
module tb_num_sep_drain_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        sep_buf_clear;
  logic        sep_done = 1'b0;
  logic        sep_invalid = 1'b0;
  logic [11:0] sep_num_count = '0;
  logic [10:0] sep_rd_addr;
  logic [31:0] sep_rd_data;
  logic [31:0] out_data;
  logic [10:0] out_index;
  logic        out_valid;
  logic        out_last;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        ok_pulse;
  logic        err_pulse;
  logic [1:0]  err_code;

  typedef struct packed {
    logic [31:0] data;
    logic [10:0] index;
    logic        last;
  } elem_t;

  elem_t       exp_q[$];
  logic [31:0] mem [0:2047];
  int          vectors = 0;
  int          miscompares = 0;
  int          hs_count = 0;

  num_sep_drain_ctrl #(
    .DATA_WIDTH    (32),
    .ADDR_WIDTH    (11),
    .MAX_COUNT     (2048),
    .CLEAR_CYCLES  (4),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .sep_buf_clear(sep_buf_clear),
    .sep_done     (sep_done),
    .sep_invalid  (sep_invalid),
    .sep_num_count(sep_num_count),
    .sep_rd_addr  (sep_rd_addr),
    .sep_rd_data  (sep_rd_data),
    .out_data     (out_data),
    .out_index    (out_index),
    .out_valid    (out_valid),
    .out_last     (out_last),
    .out_ready    (out_ready),
    .busy         (busy),
    .ok_pulse     (ok_pulse),
    .err_pulse    (err_pulse),
    .err_code     (err_code)
  );

  always #5 clk = ~clk;

  // Synchronous-read result RAM of the separator.
  always @(posedge clk) sep_rd_data <= mem[sep_rd_addr];

  // Stream monitor: sampled on the falling edge, inputs only move just after rising edges.
  elem_t got, exp_e, stall_val;
  bit    stall_prev = 1'b0;
  bit    guard_prev = 1'b0;
  always @(negedge clk) begin
    got = {out_data, out_index, out_last};
    if (stall_prev && !guard_prev) begin
      vectors++;
      if (!out_valid || (got !== stall_val)) begin
        miscompares++;
        $display("[TB] FAIL stall_hold got valid=%0b %h/%0d/%0b want valid=1 %h/%0d/%0b",
                 out_valid, got.data, got.index, got.last,
                 stall_val.data, stall_val.index, stall_val.last);
      end
    end
    if (out_valid && out_ready && !rst) begin
      hs_count++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_elem got %h/%0d/%0b want none",
                 got.data, got.index, got.last);
      end else begin
        exp_e = exp_q.pop_front();
        if (got !== exp_e) begin
          miscompares++;
          $display("[TB] FAIL stream_elem got %h/%0d/%0b want %h/%0d/%0b",
                   got.data, got.index, got.last, exp_e.data, exp_e.index, exp_e.last);
        end
      end
    end
    stall_prev = out_valid && !out_ready;
    stall_val  = got;
    guard_prev = abort || rst;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Counts buf_clear cycles; returns positioned in the first WAIT cycle.
  task automatic wait_clear(output int n);
    n = 0;
    while (sep_buf_clear && n < 20) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    vectors++;
    if ({sep_buf_clear, out_valid, out_last, busy, ok_pulse, err_pulse} !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags got %b want 000000",
               {sep_buf_clear, out_valid, out_last, busy, ok_pulse, err_pulse});
    end
    vectors++;
    if ({out_data, out_index, sep_rd_addr, err_code} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_values got data=%h idx=%0d addr=%0d code=%0d want 0",
               out_data, out_index, sep_rd_addr, err_code);
    end
    step();
    step();
    rst = 1'b0;
    step();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_idle busy got %b want 0", busy);
    end
  endtask

  task automatic test_stall();
    int  n, hs0, cyc;
    bit  seen_ok;
    logic [1:0] code;
    mem[0] = 32'd123;
    exp_q.push_back('{data: 32'd123, index: 11'd0, last: 1'b1});
    out_ready = 1'b0;
    hs0 = hs_count;
    do_start();
    wait_clear(n);
    sep_done = 1'b1;
    sep_num_count = 12'd1;
    seen_ok = 1'b0;
    code = 2'bxx;
    cyc = 0;
    while (!seen_ok && cyc < 100) begin
      cyc++;
      out_ready = (cyc % 4 == 0);
      step();
      if (ok_pulse) begin
        seen_ok = 1'b1;
        code = err_code;
      end
    end
    out_ready = 1'b1;
    sep_done = 1'b0;
    vectors++;
    if (!seen_ok || code !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL stall_ok got ok=%0b code=%0d want ok=1 code=0", seen_ok, code);
    end
    vectors++;
    if (hs_count - hs0 != 1) begin
      miscompares++;
      $display("[TB] FAIL stall_handshakes got %0d want 1", hs_count - hs0);
    end
    step();
  endtask

  task automatic test_stream();
    int  n, hs0, okc;
    bit  seen_ok, seen_err;
    logic [1:0] code;
    mem[0] = 32'd10;
    mem[1] = 32'd20;
    mem[2] = 32'hFFFF_FFE2;
    exp_q.push_back('{data: 32'd10,         index: 11'd0, last: 1'b0});
    exp_q.push_back('{data: 32'd20,         index: 11'd1, last: 1'b0});
    exp_q.push_back('{data: 32'hFFFF_FFE2,  index: 11'd2, last: 1'b1});
    out_ready = 1'b1;
    hs0 = hs_count;
    do_start();
    wait_clear(n);
    vectors++;
    if (n != 4) begin
      miscompares++;
      $display("[TB] FAIL clear_len got %0d want 4", n);
    end
    step();
    step();
    sep_done = 1'b1;
    sep_num_count = 12'd3;
    seen_ok = 1'b0;
    seen_err = 1'b0;
    okc = 0;
    code = 2'bxx;
    for (int c = 0; c < 100 && !seen_ok; c++) begin
      step();
      if (err_pulse) seen_err = 1'b1;
      if (ok_pulse) begin
        seen_ok = 1'b1;
        okc++;
        code = err_code;
      end
    end
    sep_done = 1'b0;
    vectors++;
    if (!seen_ok || seen_err || code !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL stream_result got ok=%0b err=%0b code=%0d want ok=1 err=0 code=0",
               seen_ok, seen_err, code);
    end
    vectors++;
    if ((hs_count - hs0 != 3) || (exp_q.size() != 0)) begin
      miscompares++;
      $display("[TB] FAIL stream_count got %0d handshakes, %0d left want 3, 0",
               hs_count - hs0, exp_q.size());
    end
    step();
    if (ok_pulse) okc++;
    vectors++;
    if (busy !== 1'b0 || okc != 1) begin
      miscompares++;
      $display("[TB] FAIL stream_end got busy=%0b okpulses=%0d want busy=0 okpulses=1", busy, okc);
    end
  endtask

  task automatic test_bad_count();
    int n;
    bit seen_err, seen_valid;
    logic [10:0] addr0;
    logic [1:0]  code;
    logic [11:0] counts[2];
    counts[0] = 12'd0;
    counts[1] = 12'd2049;
    foreach (counts[k]) begin
      addr0 = sep_rd_addr;
      do_start();
      wait_clear(n);
      sep_done = 1'b1;
      sep_num_count = counts[k];
      seen_err = 1'b0;
      seen_valid = 1'b0;
      code = 2'bxx;
      for (int c = 0; c < 20 && !seen_err; c++) begin
        step();
        if (out_valid) seen_valid = 1'b1;
        if (err_pulse) begin
          seen_err = 1'b1;
          code = err_code;
        end
      end
      sep_done = 1'b0;
      vectors++;
      if (!seen_err || code !== 2'd3 || seen_valid) begin
        miscompares++;
        $display("[TB] FAIL bad_count_%0d got err=%0b code=%0d valid=%0b want err=1 code=3 valid=0",
                 counts[k], seen_err, code, seen_valid);
      end
      vectors++;
      if (sep_rd_addr !== addr0) begin
        miscompares++;
        $display("[TB] FAIL bad_count_addr got %0d want %0d", sep_rd_addr, addr0);
      end
      step();
    end
  endtask

  task automatic test_invalid();
    int n;
    bit seen_err, seen_valid, seen_ok;
    logic [1:0] code;
    do_start();
    wait_clear(n);
    step();
    step();
    step();
    sep_invalid = 1'b1;
    sep_done = 1'b1;
    sep_num_count = 12'd5;
    seen_err = 1'b0;
    seen_valid = 1'b0;
    seen_ok = 1'b0;
    code = 2'bxx;
    for (int c = 0; c < 20 && !seen_err; c++) begin
      step();
      if (out_valid) seen_valid = 1'b1;
      if (ok_pulse) seen_ok = 1'b1;
      if (err_pulse) begin
        seen_err = 1'b1;
        code = err_code;
      end
    end
    vectors++;
    if (!seen_err || code !== 2'd1 || seen_valid || seen_ok) begin
      miscompares++;
      $display("[TB] FAIL invalid got err=%0b code=%0d valid=%0b ok=%0b want 1,1,0,0",
               seen_err, code, seen_valid, seen_ok);
    end
    step();
    vectors++;
    if (busy !== 1'b0 || err_pulse !== 1'b0 || err_code !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL invalid_after got busy=%0b err=%0b code=%0d want 0,0,1",
               busy, err_pulse, err_code);
    end
    sep_invalid = 1'b0;
    sep_done = 1'b0;
  endtask

  task automatic test_timeout();
    int n, k;
    do_start();
    vectors++;
    if (err_code !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL start_clears_code got %0d want 0", err_code);
    end
    wait_clear(n);
    vectors++;
    if (n != 4) begin
      miscompares++;
      $display("[TB] FAIL timeout_clear_len got %0d want 4", n);
    end
    k = 0;
    while (!err_pulse && k < 200) begin
      step();
      k++;
    end
    vectors++;
    if (k != 50 || err_code !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL timeout got cycles=%0d code=%0d want 50, 2", k, err_code);
    end
    step();
  endtask

  task automatic test_abort();
    int  n, hs0;
    bit  found, seen_ok, pulses;
    mem[0] = 32'd0;
    mem[1] = 32'd0;
    mem[2] = 32'd0;
    exp_q.push_back('{data: 32'd0, index: 11'd0, last: 1'b0});
    out_ready = 1'b0;
    do_start();
    wait_clear(n);
    sep_done = 1'b1;
    sep_num_count = 12'd3;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      step();
      if (out_valid && out_index == 11'd0) found = 1'b1;
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (out_valid && out_index == 11'd1) found = 1'b1;
      else step();
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("[TB] FAIL abort_reach_elem1 got found=0 want 1");
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    sep_done = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || ok_pulse !== 1'b0 || err_pulse !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_effect got valid=%0b busy=%0b ok=%0b err=%0b want all 0",
               out_valid, busy, ok_pulse, err_pulse);
    end
    pulses = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (ok_pulse || err_pulse || busy) pulses = 1'b1;
    end
    vectors++;
    if (pulses) begin
      miscompares++;
      $display("[TB] FAIL abort_quiet got activity=1 want 0");
    end
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_over_start got busy=%0b want 0", busy);
    end
    mem[0] = 32'd7;
    exp_q.push_back('{data: 32'd7, index: 11'd0, last: 1'b1});
    out_ready = 1'b1;
    hs0 = hs_count;
    do_start();
    wait_clear(n);
    sep_done = 1'b1;
    sep_num_count = 12'd1;
    seen_ok = 1'b0;
    for (int c = 0; c < 30 && !seen_ok; c++) begin
      step();
      if (ok_pulse) seen_ok = 1'b1;
    end
    sep_done = 1'b0;
    vectors++;
    if (!seen_ok || hs_count - hs0 != 1 || exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL after_abort got ok=%0b hs=%0d left=%0d want 1,1,0",
               seen_ok, hs_count - hs0, exp_q.size());
    end
    step();
  endtask

  task automatic test_async_reset();
    int n;
    do_start();
    wait_clear(n);
    step();
    step();
    step();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL async_pre busy got %b want 1", busy);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({busy, sep_buf_clear, out_valid, out_last, ok_pulse, err_pulse} !== 6'b0 ||
        {out_data, out_index, sep_rd_addr, err_code} !== '0) begin
      miscompares++;
      $display("[TB] FAIL async_reset got busy=%0b data=%h idx=%0d addr=%0d want all 0",
               busy, out_data, out_index, sep_rd_addr);
    end
    #10;
    rst = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got no finish want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_stall();
    test_stream();
    test_bad_count();
    test_invalid();
    test_timeout();
    test_abort();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
